// File: rtl/game_update_scheduler_if.sv
// rtl/game_update_scheduler_if.sv - frame/stage handshake and status bundle of the update scheduler
interface game_update_scheduler_if #(
  parameter int N_STAGES = 4
);
  logic                frame_stb;
  logic                enable;
  logic                clr_err;
  logic [N_STAGES-1:0] stage_done;
  logic [N_STAGES-1:0] stage_start;
  logic                busy;
  logic [2:0]          cur_stage;
  logic                update_done;
  logic [15:0]         frame_count;
  logic [7:0]          overrun_cnt;
  logic                timeout_err;

  modport master (
    output frame_stb, enable, clr_err, stage_done,
    input  stage_start, busy, cur_stage, update_done, frame_count, overrun_cnt, timeout_err
  );

  modport slave (
    input  frame_stb, enable, clr_err, stage_done,
    output stage_start, busy, cur_stage, update_done, frame_count, overrun_cnt, timeout_err
  );
endinterface

// File: rtl/game_update_scheduler.sv
// rtl/game_update_scheduler.sv - per-frame sequencer starting update units one at a time
module game_update_scheduler #(
  parameter int N_STAGES       = 4,
  parameter int FRAME_DIVIDER  = 1,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                     clk,
  input  logic                     rst,
  game_update_scheduler_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  localparam int DIV_W = (FRAME_DIVIDER > 1) ? $clog2(FRAME_DIVIDER) : 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(FRAME_DIVIDER - 1);
  localparam logic [WD_W-1:0]  WD_LAST    = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]       LAST_STAGE = 3'(N_STAGES - 1);

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [WD_W-1:0]     wdog_q, wdog_d;
  logic [2:0]          cur_stage_q, cur_stage_d;
  logic [N_STAGES-1:0] stage_start_q, stage_start_d;
  logic                busy_q, busy_d;
  logic                update_done_q, update_done_d;
  logic [15:0]         frame_count_q, frame_count_d;
  logic [7:0]          overrun_q, overrun_d;
  logic                timeout_err_q, timeout_err_d;

  logic       frame_ok;
  logic [7:0] done_ext;
  logic [7:0] next_onehot;

  always_comb begin
    state_d       = state_q;
    div_cnt_d     = div_cnt_q;
    wdog_d        = wdog_q;
    cur_stage_d   = cur_stage_q;
    stage_start_d = '0;
    busy_d        = busy_q;
    update_done_d = 1'b0;
    frame_count_d = frame_count_q;
    overrun_d     = overrun_q;
    timeout_err_d = timeout_err_q;
    frame_ok      = bus.frame_stb && bus.enable;
    done_ext      = 8'(bus.stage_done);
    next_onehot   = 8'b1 << (cur_stage_q + 3'd1);

    // Outputs are registered, so each is loaded on the transition into the state that shows it.
    case (state_q)
      IDLE: begin
        if (frame_ok) begin
          if (div_cnt_q == DIV_LAST) begin
            div_cnt_d     = '0;
            cur_stage_d   = 3'd0;
            stage_start_d = N_STAGES'(1);
            busy_d        = 1'b1;
            state_d       = START;
          end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
          end
        end
      end
      START: begin
        wdog_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (done_ext[cur_stage_q]) begin
          if (cur_stage_q < LAST_STAGE) begin
            cur_stage_d   = cur_stage_q + 3'd1;
            stage_start_d = next_onehot[N_STAGES-1:0];
            state_d       = START;
          end else begin
            frame_count_d = frame_count_q + 16'd1;
            update_done_d = 1'b1;
            busy_d        = 1'b0;
            cur_stage_d   = 3'd0;
            state_d       = DONE;
          end
        end else if (wdog_q == WD_LAST) begin
          timeout_err_d = 1'b1;
          update_done_d = 1'b1;
          busy_d        = 1'b0;
          cur_stage_d   = 3'd0;
          state_d       = DONE;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (frame_ok && (state_q != IDLE) && (overrun_q != 8'hFF)) begin
      overrun_d = overrun_q + 8'd1;
    end

    if (bus.clr_err) begin
      overrun_d     = 8'd0;
      timeout_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      div_cnt_q     <= '0;
      wdog_q        <= '0;
      cur_stage_q   <= 3'd0;
      stage_start_q <= '0;
      busy_q        <= 1'b0;
      update_done_q <= 1'b0;
      frame_count_q <= 16'd0;
      overrun_q     <= 8'd0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_cnt_q     <= div_cnt_d;
      wdog_q        <= wdog_d;
      cur_stage_q   <= cur_stage_d;
      stage_start_q <= stage_start_d;
      busy_q        <= busy_d;
      update_done_q <= update_done_d;
      frame_count_q <= frame_count_d;
      overrun_q     <= overrun_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.stage_start = stage_start_q;
  assign bus.busy        = busy_q;
  assign bus.cur_stage   = cur_stage_q;
  assign bus.update_done = update_done_q;
  assign bus.frame_count = frame_count_q;
  assign bus.overrun_cnt = overrun_q;
  assign bus.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_game_update_scheduler.sv
// tb/tb_game_update_scheduler.sv - directed checks of the update scheduler
module tb_game_update_scheduler;
  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   done_seen;
  logic [3:0] extra;

  always #5 clk = ~clk;

  game_update_scheduler_if #(.N_STAGES(4)) bus_a ();
  game_update_scheduler_if #(.N_STAGES(4)) bus_b ();

  // Unit A: every frame launches, short watchdog. Unit B: divide by 3, long watchdog.
  game_update_scheduler #(.N_STAGES(4), .FRAME_DIVIDER(1), .TIMEOUT_CYCLES(16)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a)
  );

  game_update_scheduler #(.N_STAGES(4), .FRAME_DIVIDER(3), .TIMEOUT_CYCLES(65535)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL tb_timeout: observed no finish expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    bus_a.frame_stb = 0; bus_a.enable = 0; bus_a.clr_err = 0; bus_a.stage_done = '0;
    bus_b.frame_stb = 0; bus_b.enable = 0; bus_b.clr_err = 0; bus_b.stage_done = '0;
    tick();
    chk("rst_busy", bus_a.busy, 0);
    chk("rst_start", bus_a.stage_start, 0);
    chk("rst_cur", bus_a.cur_stage, 0);
    chk("rst_done", bus_a.update_done, 0);
    chk("rst_fc", bus_a.frame_count, 0);
    chk("rst_ovr", bus_b.overrun_cnt, 0);
    chk("rst_terr", bus_a.timeout_err, 0);
    rst_a = 1; rst_b = 1;
    bus_a.enable = 1; bus_b.enable = 1;
    tick();

    // Normal sequence, each unit answers 3 cycles after its start.
    bus_a.frame_stb = 1; tick(); bus_a.frame_stb = 0;
    for (int s = 0; s < 4; s++) begin
      chk($sformatf("t1_start%0d", s), bus_a.stage_start, 32'(1 << s));
      chk($sformatf("t1_cur%0d", s), bus_a.cur_stage, s);
      chk($sformatf("t1_busy%0d", s), bus_a.busy, 1);
      tick();
      chk($sformatf("t1_gap%0d", s), bus_a.stage_start, 0);
      tick(); tick();
      bus_a.stage_done = 4'(1 << s);
      tick();
      bus_a.stage_done = '0;
    end
    chk("t1_upd", bus_a.update_done, 1);
    chk("t1_busy_end", bus_a.busy, 0);
    chk("t1_cur_end", bus_a.cur_stage, 0);
    chk("t1_fc", bus_a.frame_count, 1);
    tick();
    chk("t1_upd_pulse", bus_a.update_done, 0);

    // Stuck-high done: one stage every 2 cycles.
    bus_a.stage_done = 4'hF;
    bus_a.frame_stb = 1; tick(); bus_a.frame_stb = 0;
    for (int s = 0; s < 4; s++) begin
      chk($sformatf("t5_start%0d", s), bus_a.stage_start, 32'(1 << s));
      chk($sformatf("t5_cur%0d", s), bus_a.cur_stage, s);
      tick();
      chk($sformatf("t5_gap%0d", s), bus_a.stage_start, 0);
      tick();
    end
    chk("t5_upd", bus_a.update_done, 1);
    chk("t5_fc", bus_a.frame_count, 2);
    bus_a.stage_done = '0;
    tick();

    // Done on wrong indices only: stage 0 never advances and the watchdog aborts.
    bus_a.stage_done = 4'b1110;
    bus_a.frame_stb = 1; tick(); bus_a.frame_stb = 0;
    chk("t5w_start0", bus_a.stage_start, 1);
    extra = '0;
    for (int i = 0; i < 16; i++) begin
      tick();
      extra = extra | bus_a.stage_start;
    end
    chk("t5w_not_yet", bus_a.update_done, 0);
    tick();
    chk("t5w_upd", bus_a.update_done, 1);
    chk("t5w_terr", bus_a.timeout_err, 1);
    chk("t5w_fc", bus_a.frame_count, 2);
    chk("t5w_extra", extra, 0);
    bus_a.stage_done = '0;
    tick();
    bus_a.clr_err = 1; tick(); bus_a.clr_err = 0;
    chk("t5w_clr", bus_a.timeout_err, 0);

    // Unit 2 never responds.
    bus_a.frame_stb = 1; tick(); bus_a.frame_stb = 0;
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("t3_start%0d", s), bus_a.stage_start, 32'(1 << s));
      tick(); tick(); tick();
      bus_a.stage_done = 4'(1 << s);
      tick();
      bus_a.stage_done = '0;
    end
    chk("t3_start2", bus_a.stage_start, 4);
    extra = '0;
    for (int i = 0; i < 16; i++) begin
      tick();
      extra = extra | bus_a.stage_start;
    end
    chk("t3_not_yet", bus_a.update_done, 0);
    tick();
    chk("t3_upd", bus_a.update_done, 1);
    chk("t3_terr", bus_a.timeout_err, 1);
    chk("t3_fc", bus_a.frame_count, 2);
    chk("t3_no_start3", extra, 0);
    tick();

    // Asynchronous reset while waiting on stage 1.
    bus_a.frame_stb = 1; tick(); bus_a.frame_stb = 0;
    tick(); tick();
    bus_a.stage_done = 4'b0001; tick(); bus_a.stage_done = '0;
    chk("t6_start1", bus_a.stage_start, 2);
    tick();
    chk("t6_cur1", bus_a.cur_stage, 1);
    #2 rst_a = 0;
    #1;
    chk("t6_busy", bus_a.busy, 0);
    chk("t6_cur", bus_a.cur_stage, 0);
    chk("t6_terr", bus_a.timeout_err, 0);
    chk("t6_fc", bus_a.frame_count, 0);
    chk("t6_upd", bus_a.update_done, 0);
    #1 rst_a = 1;
    tick();
    chk("t6_no_upd", bus_a.update_done, 0);
    bus_a.frame_stb = 1; tick(); bus_a.frame_stb = 0;
    chk("t6_restart", bus_a.stage_start, 1);
    chk("t6_restart_cur", bus_a.cur_stage, 0);

    // Frame divider of 3: six idle frames give two sequences.
    bus_b.stage_done = 4'hF;
    done_seen = 0;
    for (int f = 1; f <= 6; f++) begin
      bus_b.frame_stb = 1; tick(); bus_b.frame_stb = 0;
      chk($sformatf("t2_busy%0d", f), bus_b.busy, (f % 3 == 0) ? 1 : 0);
      chk($sformatf("t2_start%0d", f), bus_b.stage_start, (f % 3 == 0) ? 1 : 0);
      for (int k = 0; k < 11; k++) begin
        tick();
        if (bus_b.update_done) done_seen++;
      end
    end
    chk("t2_seqs", done_seen, 2);
    chk("t2_fc", bus_b.frame_count, 2);
    chk("t2_ovr", bus_b.overrun_cnt, 0);

    // Overrun saturation while held in WAIT.
    bus_b.stage_done = '0;
    for (int f = 0; f < 3; f++) begin
      bus_b.frame_stb = 1; tick(); bus_b.frame_stb = 0; tick();
    end
    chk("t4_busy", bus_b.busy, 1);
    for (int i = 0; i < 300; i++) begin
      bus_b.frame_stb = 1; tick(); bus_b.frame_stb = 0; tick();
      if (i == 9) chk("t4_ovr10", bus_b.overrun_cnt, 10);
    end
    chk("t4_ovr_sat", bus_b.overrun_cnt, 255);
    chk("t4_still_busy", bus_b.busy, 1);
    bus_b.clr_err = 1; tick(); bus_b.clr_err = 0;
    chk("t4_clr", bus_b.overrun_cnt, 0);
    bus_b.clr_err = 1; bus_b.frame_stb = 1; tick(); bus_b.clr_err = 0; bus_b.frame_stb = 0;
    chk("t4_clr_wins", bus_b.overrun_cnt, 0);
    bus_b.enable = 0;
    bus_b.frame_stb = 1; tick(); bus_b.frame_stb = 0;
    chk("t4_dis_no_ovr", bus_b.overrun_cnt, 0);

    // With enable low the running sequence still completes.
    bus_b.stage_done = 4'hF;
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus_b.update_done) done_seen++;
    end
    chk("t4_finish", done_seen, 1);
    chk("t4_fc", bus_b.frame_count, 3);
    chk("t4_terr", bus_b.timeout_err, 0);

    // Dropped frames left the divider untouched: three more frames needed.
    bus_b.enable = 1;
    for (int f = 1; f <= 3; f++) begin
      bus_b.frame_stb = 1; tick(); bus_b.frame_stb = 0;
      chk($sformatf("t4_div%0d", f), bus_b.stage_start, (f == 3) ? 1 : 0);
      if (f < 3) tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
